// File: rtl/demux2_sched_pkg.sv
// -----------------------------------------------------------------------------
// demux2_sched_pkg
// Shared types and helpers for the demux2 control-channel scheduler.
//   state_t  : handshake FSM states
//   cred_t   : per-output credit counter (saturates at all-ones)
//   wt_t     : per-output weight (0 disables the output)
//   pick_fn  : weighted round-robin selection between out0/out1
//   cred_upd : credit counter update with saturation/overflow flag
// -----------------------------------------------------------------------------
package demux2_sched_pkg;

  localparam int CW = 4;  // credit counter width
  localparam int WW = 3;  // weight width

  typedef logic [CW-1:0] cred_t;
  typedef logic [WW-1:0] wt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;    // a token may be issued
    logic sel;      // 0 -> out0, 1 -> out1
    logic restart;  // staying on cur after its turn ended: run starts over
  } pick_t;

  localparam cred_t CMAX = {CW{1'b1}};
  localparam cred_t CONE = {{(CW-1){1'b0}}, 1'b1};

  // Priority: finish cur's turn, else hand over, else keep cur alone.
  function automatic pick_t pick_fn(input logic elig0, input logic elig1,
                                    input logic cur, input logic run_lt_w);
    pick_t p;
    logic  elig_cur;
    logic  elig_oth;
    elig_cur  = cur ? elig1 : elig0;
    elig_oth  = cur ? elig0 : elig1;
    p.valid   = 1'b0;
    p.sel     = cur;
    p.restart = 1'b0;
    if (elig_cur && run_lt_w) begin
      p.valid = 1'b1;
      p.sel   = cur;
    end else if (elig_oth) begin
      p.valid = 1'b1;
      p.sel   = ~cur;
    end else if (elig_cur) begin
      p.valid   = 1'b1;
      p.sel     = cur;
      p.restart = 1'b1;
    end else begin
      p.valid = 1'b0;
    end
    return p;
  endfunction

  // Returns {overflow, next_count}. A simultaneous take and return cancel,
  // so only a lone return can hit the saturated value and be dropped.
  function automatic logic [CW:0] cred_upd(input cred_t c, input logic inc,
                                           input logic dec);
    logic [CW:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CMAX) begin
        r = {1'b1, c};
      end else begin
        r = {1'b0, c + CONE};
      end
    end else if (dec && !inc) begin
      r = {1'b0, c - CONE};
    end else begin
      r = {1'b0, c};
    end
    return r;
  endfunction

endpackage

// File: rtl/demux2_sched_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// D-flop synchronizer for a single asynchronous bit; D=0 is a plain wire.
//   clk  in  clock
//   rst  in  synchronous reset, active-low (clears the chain)
//   i_d  in  asynchronous input
//   o_q  out synchronized output
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int D = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (D == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_flops
      logic [D-1:0] r_q;

      // Shift the input through D flops.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_q <= {D{1'b0}};
        end else begin
          r_q[0] <= i_d;
          for (int k = 1; k < D; k++) begin
            r_q[k] <= r_q[k-1];
          end
        end
      end

      assign o_q = r_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/demux2_sched.sv
// -----------------------------------------------------------------------------
// demux2_sched
// Clocked scheduler for the control channel of demux2. Each token is steered
// to out0 or out1 by weighted round-robin, gated by per-output credits that
// downstream consumers return. The clocked FSM drives the 4-phase rctl/actl
// handshake, with one setup cycle so dctl is stable before rctl rises.
// The demux2 instance is connected to rctl_o/dctl_o/actl_i by the enclosing
// level.
//   clk      in  clock
//   rst      in  synchronous reset, active-low
//   en_i     in  allow new tokens (checked in IDLE only)
//   w0_i     in  weight of out0 (tokens per turn, 0 disables)
//   w1_i     in  weight of out1
//   cred0_i  in  one-cycle pulse: out0 credit returned
//   cred1_i  in  one-cycle pulse: out1 credit returned
//   rctl_o   out control request (4-phase)
//   dctl_o   out control data, 0 -> out0, 1 -> out1
//   actl_i   in  control acknowledge (asynchronous)
//   busy_o   out handshake in progress
//   ovf_o    out sticky: a credit was returned to a saturated counter
// -----------------------------------------------------------------------------
module demux2_sched
  import demux2_sched_pkg::*;
#(
  parameter int CINIT = 2,
  parameter int SYNC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  wt_t  w0_i,
  input  wt_t  w1_i,
  input  logic cred0_i,
  input  logic cred1_i,
  output logic rctl_o,
  output logic dctl_o,
  input  logic actl_i,
  output logic busy_o,
  output logic ovf_o
);

  localparam cred_t C_RST  = cred_t'(CINIT);
  localparam wt_t   WT_ONE = {{(WW-1){1'b0}}, 1'b1};

  state_t      r_state;
  logic        r_rctl;
  logic        r_dctl;
  logic        r_busy;
  logic        r_ovf;
  cred_t       r_c0;
  cred_t       r_c1;
  logic        r_cur;
  wt_t         r_run;

  logic        w_actl_s;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_run_lt_w;
  pick_t       w_pick;
  state_t      w_state_nxt;
  logic        w_start;
  logic [CW:0] w_c0_upd;
  logic [CW:0] w_c1_upd;

  sync_chain #(.D(SYNC)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (actl_i),
    .o_q (w_actl_s)
  );

  assign w_elig0    = (r_c0 != {CW{1'b0}}) && (w0_i != {WW{1'b0}});
  assign w_elig1    = (r_c1 != {CW{1'b0}}) && (w1_i != {WW{1'b0}});
  assign w_run_lt_w = r_cur ? (r_run < w1_i) : (r_run < w0_i);
  assign w_pick     = pick_fn(w_elig0, w_elig1, r_cur, w_run_lt_w);

  // Next-state logic for the handshake FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en_i && w_pick.valid) begin
          w_state_nxt = SETUP;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        w_state_nxt = REQ;
      end
      REQ: begin
        if (w_actl_s) begin
          w_state_nxt = REL;
        end else begin
          w_state_nxt = REQ;
        end
      end
      REL: begin
        if (!w_actl_s) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = REL;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_c0_upd = cred_upd(r_c0, cred0_i, w_start && !w_pick.sel);
  assign w_c1_upd = cred_upd(r_c1, cred1_i, w_start &&  w_pick.sel);

  // State, registered outputs, credits and round-robin bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rctl  <= 1'b0;
      r_dctl  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_c0    <= C_RST;
      r_c1    <= C_RST;
      r_cur   <= 1'b0;
      r_run   <= {WW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_rctl  <= (w_state_nxt == REQ);
      r_busy  <= (w_state_nxt != IDLE);
      r_c0    <= w_c0_upd[CW-1:0];
      r_c1    <= w_c1_upd[CW-1:0];
      r_ovf   <= r_ovf | w_c0_upd[CW] | w_c1_upd[CW];
      if (w_start) begin
        r_dctl <= w_pick.sel;
        // run < w guarantees the increment cannot wrap.
        if ((w_pick.sel == r_cur) && !w_pick.restart) begin
          r_run <= r_run + WT_ONE;
        end else begin
          r_cur <= w_pick.sel;
          r_run <= WT_ONE;
        end
      end else begin
        r_dctl <= r_dctl;
      end
    end
  end

  assign rctl_o = r_rctl;
  assign dctl_o = r_dctl;
  assign busy_o = r_busy;
  assign ovf_o  = r_ovf;

endmodule
